// File: rtl/qe_sample_scheduler_pkg.sv
// qe_sample_scheduler_pkg: shared state type and constants
// for the QE sample scheduler and its period timer.
package qe_sample_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    START,
    SELECT,
    REQ_HI,
    REQ_LO,
    DONE
  } sched_state_t;

  localparam int unsigned MIN_SAMPLE_PERIOD = 2;
  localparam int unsigned DEF_ACK_TIMEOUT   = 15;
  localparam int unsigned DEF_NUM_CH        = 4;

  // Reload value for a period, with 0 and 1 treated as 2.
  function automatic logic [31:0] period_reload(
    input logic [31:0] p
  );
    if (p < MIN_SAMPLE_PERIOD)
      return 32'(MIN_SAMPLE_PERIOD - 1);
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/qe_sample_scheduler_period_timer.sv
// qe_period_timer: 32-bit reload/decrement down-counter
// that pulses o_tick on expiry and reloads itself.
import qe_sample_scheduler_pkg::*;

module qe_period_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_run,
  input  logic [31:0] i_period,
  output logic        o_tick
);

  logic [31:0] r_cnt;
  logic [31:0] w_reload;

  assign w_reload = period_reload(i_period);
  assign o_tick   = i_run && (r_cnt == 32'd0);

  // Load on demand, else count down and reload on expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load || o_tick)
      r_cnt <= w_reload;
    else if (i_run)
      r_cnt <= r_cnt - 32'd1;
  end

endmodule

// File: rtl/qe_sample_scheduler.sv
// qe_sample_scheduler: periodic snapshot sweeps over QE channels.
// Optional sweep_timestamp output: define QE_SCHED_TIMESTAMP_EN.
import qe_sample_scheduler_pkg::*;

module qe_sample_scheduler #(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned SWEEP_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   single_shot,
  input  logic [31:0]            sample_period,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic [NUM_CH-1:0]      latch_ack,
  output logic [NUM_CH-1:0]      latch_req,
  output logic                   busy,
  output logic                   sweep_done,
  output logic [SWEEP_CNT_W-1:0] sweep_count,
  output logic [NUM_CH-1:0]      timeout_flags,
  output logic                   overrun,
`ifdef QE_SCHED_TIMESTAMP_EN
  output logic [31:0]            sweep_timestamp,
`endif
  input  logic                   clear_flags
);

  localparam int unsigned IDX_W = $clog2(NUM_CH) + 1;
  localparam int unsigned PH_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(ACK_TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] ONE     = NUM_CH'(1);

  sched_state_t r_state;
  sched_state_t w_next;

  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [PH_W-1:0]        r_phase;
  logic [NUM_CH-1:0]      r_active;
  logic [NUM_CH-1:0]      r_req;
  logic                   r_busy;
  logic                   r_done;
  logic [SWEEP_CNT_W-1:0] r_count;
  logic [NUM_CH-1:0]      r_tflags;
  logic                   r_ovr;

  logic [NUM_CH-1:0] w_sel;
  logic              w_ack;
  logic              w_hit;
  logic              w_tick;
  logic              w_timeout;
  logic              w_ovr_set;
  logic              w_in_sweep;

  assign w_sel = ONE << r_idx;
  assign w_ack = |(latch_ack & w_sel);
  assign w_hit = |(r_active & w_sel);

  assign w_in_sweep = (r_state != IDLE) &&
                      (r_state != WAIT_PERIOD);
  assign w_ovr_set  = w_tick && w_in_sweep;

  qe_period_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == IDLE),
    .i_run    (enable && (r_state != IDLE)),
    .i_period (sample_period),
    .o_tick   (w_tick)
  );

  // Next state, next scan index and timeout detection.
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable)
          w_next = WAIT_PERIOD;
        else if (single_shot)
          w_next = START;
      end
      WAIT_PERIOD: begin
        if (!enable)
          w_next = IDLE;
        else if (w_tick)
          w_next = START;
      end
      START: begin
        w_idx_nxt = '0;
        w_next = (ch_mask == '0) ? DONE : SELECT;
      end
      SELECT: begin
        if (w_hit)
          w_next = REQ_HI;
        else if (r_idx >= LAST_IDX)
          w_next = DONE;
        else
          w_idx_nxt = r_idx + IDX_W'(1);
      end
      REQ_HI: begin
        if (w_ack) begin
          w_next = REQ_LO;
        end else if (r_phase == PH_LAST) begin
          w_timeout = 1'b1;
          w_next    = SELECT;
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      REQ_LO: begin
        if (!w_ack) begin
          w_next    = SELECT;
          w_idx_nxt = r_idx + IDX_W'(1);
        end else if (r_phase == PH_LAST) begin
          w_timeout = 1'b1;
          w_next    = SELECT;
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        w_next = enable ? WAIT_PERIOD : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, scan index and per-phase handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      if (w_next != r_state)
        r_phase <= '0;
      else if (r_phase != PH_LAST)
        r_phase <= r_phase + PH_W'(1);
    end
  end

  // Sweep bookkeeping and the registered request vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      r_req    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (r_state == START)
        r_active <= ch_mask;
      r_req <= (w_next == REQ_HI) ? (ONE << w_idx_nxt) : '0;
      if (r_state == START)
        r_busy <= 1'b1;
      else if (r_state == DONE)
        r_busy <= 1'b0;
      r_done <= (r_state == DONE);
      if (r_state == DONE)
        r_count <= r_count + SWEEP_CNT_W'(1);
    end
  end

  // Sticky status flags; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tflags <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_tflags <= (clear_flags ? '0 : r_tflags) |
                  (w_timeout ? w_sel : '0);
      r_ovr    <= (clear_flags ? 1'b0 : r_ovr) | w_ovr_set;
    end
  end

`ifdef QE_SCHED_TIMESTAMP_EN
  logic [31:0] r_clk_cnt;
  logic [31:0] r_tstamp;

  // Free-running clock count, captured at each sweep start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_cnt <= '0;
      r_tstamp  <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 32'd1;
      if (r_state == START)
        r_tstamp <= r_clk_cnt;
    end
  end

  assign sweep_timestamp = r_tstamp;
`endif

  assign latch_req     = r_req;
  assign busy          = r_busy;
  assign sweep_done    = r_done;
  assign sweep_count   = r_count;
  assign timeout_flags = r_tflags;
  assign overrun       = r_ovr;

endmodule
